// File: rtl/uart_pkg.sv
// Shared definitions for the buffered UART transmitter: FSM states,
// parity mode encodings and the baud divisor helper.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_ODD  = 2'b01;
  localparam logic [1:0] PAR_EVEN = 2'b10;

  // Clock cycles per serial bit; the divisor must come out at 2 or more.
  function automatic int clks_per_baud(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with first-word fall-through read data. Pushes while
// full and pops while empty are ignored; storage is not reset.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_reset_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Pointers wrap naturally at DEPTH (a power of two); count tracks occupancy.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Word storage, written only on an accepted push.
  always_ff @(posedge i_clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: FIFO front end, frame FSM with runtime parity
// and stop-bit selection, registered line and status outputs.
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 25000000,
  parameter int BAUD_RATE  = 115200,
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          i_clk,
  input  logic                          i_reset_n,
  input  logic                          i_tx_valid,
  output logic                          o_tx_ready,
  input  logic [DATA_BITS-1:0]          i_data,
  input  logic [1:0]                    i_parity_mode,
  input  logic                          i_two_stop,
  output logic                          o_serial,
  output logic                          o_tx_busy,
  output logic                          o_tx_done,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count
);

  localparam int CPB = clks_per_baud(CLK_FREQ, BAUD_RATE);
  localparam int BW  = $clog2(CPB);
  localparam int IW  = $clog2(DATA_BITS);

  tx_state_e             state, state_nxt;
  logic [BW-1:0]         baud_cnt, baud_nxt;
  logic [IW-1:0]         bit_idx, idx_nxt;
  logic                  stop_sel, stop_nxt;
  logic [DATA_BITS-1:0]  word;
  logic [1:0]            par_mode_l;
  logic                  two_stop_l;
  logic                  fifo_pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [DATA_BITS-1:0]  fifo_rd;
  logic                  bit_end;
  logic                  has_par;
  logic                  serial_c;
  logic                  done_c;

  // Even parity is the XOR of the data bits; odd parity is its inverse.
  function automatic logic calc_parity(input logic [DATA_BITS-1:0] w, input logic [1:0] mode);
    return (^w) ^ (mode == PAR_ODD);
  endfunction

  uart_sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .push      (i_tx_valid),
    .push_data (i_data),
    .pop       (fifo_pop),
    .pop_data  (fifo_rd),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (o_fifo_count)
  );

  assign o_tx_ready = !fifo_full;
  assign bit_end    = (baud_cnt == BW'(CPB - 1));
  assign has_par    = (par_mode_l == PAR_ODD) || (par_mode_l == PAR_EVEN);

  // Next-state, pop request and the line level the current state calls for.
  always_comb begin
    state_nxt = state;
    baud_nxt  = bit_end ? '0 : baud_cnt + BW'(1);
    idx_nxt   = bit_idx;
    stop_nxt  = stop_sel;
    fifo_pop  = 1'b0;
    serial_c  = 1'b1;
    done_c    = 1'b0;
    unique case (state)
      IDLE: begin
        baud_nxt = '0;
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          state_nxt = START;
        end
      end
      START: begin
        serial_c = 1'b0;
        if (bit_end) begin
          state_nxt = DATA;
          idx_nxt   = '0;
        end
      end
      DATA: begin
        serial_c = word[bit_idx];
        if (bit_end) begin
          if (bit_idx == IW'(DATA_BITS - 1)) begin
            state_nxt = has_par ? PARITY : STOP;
            stop_nxt  = 1'b0;
          end else begin
            idx_nxt = bit_idx + IW'(1);
          end
        end
      end
      PARITY: begin
        serial_c = calc_parity(word, par_mode_l);
        if (bit_end) state_nxt = STOP;
      end
      STOP: begin
        serial_c = 1'b1;
        if (bit_end) begin
          if (stop_sel == two_stop_l) begin
            done_c = 1'b1;
            if (!fifo_empty) begin
              fifo_pop  = 1'b1;
              state_nxt = START;
            end else begin
              state_nxt = IDLE;
            end
          end else begin
            stop_nxt = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FSM control registers; a reset abandons any frame in flight.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      stop_sel <= 1'b0;
    end else begin
      state    <= state_nxt;
      baud_cnt <= baud_nxt;
      bit_idx  <= idx_nxt;
      stop_sel <= stop_nxt;
    end
  end

  // Frame word and its configuration are captured together at each pop.
  always_ff @(posedge i_clk) begin
    if (fifo_pop) begin
      word       <= fifo_rd;
      par_mode_l <= i_parity_mode;
      two_stop_l <= i_two_stop;
    end
  end

  // Output register stage: line, busy and done all trail the FSM by one cycle.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      o_serial  <= 1'b1;
      o_tx_busy <= 1'b0;
      o_tx_done <= 1'b0;
    end else begin
      o_serial  <= serial_c;
      o_tx_busy <= (state != IDLE);
      o_tx_done <= done_c;
    end
  end

endmodule
